// File: rtl/cppf_link_status.sv
// Per-fiber health monitor: qualifies each BX of deframed CPPF data, runs the
// DISABLED/DOWN/LOCKING/UP lock machine and keeps saturating error counters.
module cppf_link_status #(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk_40,
    input  logic             reset,
    input  logic             fiber_enable,
    input  logic             rx_valid,
    input  logic             crc_match,
    input  logic [7:0]       link_id,
    input  logic [7:0]       expected_id,
    input  logic             cnt_clear,
    output logic             link_good,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] crc_err_cnt,
    output logic [CNT_W-1:0] id_err_cnt,
    output logic [7:0]       loss_cnt
);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_DOWN     = 3'd1,
        ST_LOCKING  = 3'd2,
        ST_UP       = 3'd3
    } state_t;

    localparam logic [7:0] LOCK_U8   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_U8 = 8'(UNLOCK_COUNT);

    state_t     state_reg;
    logic [7:0] run_reg;
    logic       link_good_reg;
    logic [7:0] loss_reg;

    logic       good;
    logic       crc_e;
    logic       id_e;
    logic [7:0] run_inc;
    logic       cnt_en;
    logic       loss_inc;
    logic [1:0] err_hit;

    assign good     = rx_valid & crc_match & (link_id == expected_id);
    assign crc_e    = rx_valid & ~crc_match;
    assign id_e     = rx_valid & crc_match & (link_id != expected_id);
    assign run_inc  = run_reg + 8'd1;
    assign cnt_en   = fiber_enable & (state_reg != ST_DISABLED);
    assign loss_inc = fiber_enable & (state_reg == ST_UP) & ~good & (run_inc == UNLOCK_U8);
    assign err_hit  = {id_e, crc_e};

    // run_reg is always 0 in DOWN, so run_inc == 1 is the first good BX of a lock attempt.
    always_ff @(posedge clk_40) begin
        if (reset) begin
            state_reg     <= fiber_enable ? ST_DOWN : ST_DISABLED;
            run_reg       <= 8'd0;
            link_good_reg <= 1'b0;
        end else if (!fiber_enable) begin
            state_reg     <= ST_DISABLED;
            run_reg       <= 8'd0;
            link_good_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_DISABLED: begin
                    state_reg     <= ST_DOWN;
                    run_reg       <= 8'd0;
                    link_good_reg <= 1'b0;
                end
                ST_DOWN, ST_LOCKING: begin
                    if (good) begin
                        if (run_inc == LOCK_U8) begin
                            state_reg     <= ST_UP;
                            run_reg       <= 8'd0;
                            link_good_reg <= 1'b1;
                        end else begin
                            state_reg     <= ST_LOCKING;
                            run_reg       <= run_inc;
                            link_good_reg <= 1'b0;
                        end
                    end else begin
                        state_reg     <= ST_DOWN;
                        run_reg       <= 8'd0;
                        link_good_reg <= 1'b0;
                    end
                end
                ST_UP: begin
                    if (good) begin
                        run_reg       <= 8'd0;
                        link_good_reg <= 1'b1;
                    end else if (run_inc == UNLOCK_U8) begin
                        state_reg     <= ST_DOWN;
                        run_reg       <= 8'd0;
                        link_good_reg <= 1'b0;
                    end else begin
                        run_reg       <= run_inc;
                        link_good_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_DOWN;
                    run_reg       <= 8'd0;
                    link_good_reg <= 1'b0;
                end
            endcase
        end
    end

    // Index 0 counts CRC errors, index 1 counts ID mismatches; a masked fiber freezes both.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_err
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk_40) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (fiber_enable) begin
                    if (cnt_clear) begin
                        cnt_reg <= '0;
                    end else if (cnt_en && err_hit[gi] && !(&cnt_reg)) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_40) begin
        if (reset) begin
            loss_reg <= 8'd0;
        end else if (fiber_enable) begin
            if (cnt_clear) begin
                loss_reg <= 8'd0;
            end else if (loss_inc && !(&loss_reg)) begin
                loss_reg <= loss_reg + 8'd1;
            end
        end
    end

    assign link_good   = link_good_reg;
    assign state       = state_reg;
    assign crc_err_cnt = g_err[0].cnt_reg;
    assign id_err_cnt  = g_err[1].cnt_reg;
    assign loss_cnt    = loss_reg;

endmodule

// File: tb/tb_cppf_link_status.sv
// Bench for cppf_link_status: three instances (default, 4-bit counters, lock/unlock of 1)
// checked against a behavioural model, a vector table and the directed lock/unlock scenarios.
module tb_cppf_link_status;

    logic clk_40 = 1'b0;
    always #12 clk_40 = ~clk_40;

    logic       reset = 1'b0;
    logic       fiber_enable = 1'b0;
    logic       rx_valid = 1'b0;
    logic       crc_match = 1'b0;
    logic [7:0] link_id = 8'h00;
    logic [7:0] expected_id = 8'h05;
    logic       cnt_clear = 1'b0;

    logic        lg_a, lg_b, lg_c;
    logic [2:0]  st_a, st_b, st_c;
    logic [15:0] crc_a, idc_a;
    logic [3:0]  crc_b, idc_b;
    logic [7:0]  crc_c, idc_c;
    logic [7:0]  loss_a, loss_b, loss_c;

    cppf_link_status #(.LOCK_COUNT(16), .UNLOCK_COUNT(4), .CNT_W(16)) u_dut (
        .clk_40(clk_40), .reset(reset), .fiber_enable(fiber_enable), .rx_valid(rx_valid),
        .crc_match(crc_match), .link_id(link_id), .expected_id(expected_id), .cnt_clear(cnt_clear),
        .link_good(lg_a), .state(st_a), .crc_err_cnt(crc_a), .id_err_cnt(idc_a), .loss_cnt(loss_a));

    cppf_link_status #(.LOCK_COUNT(16), .UNLOCK_COUNT(4), .CNT_W(4)) u_sat (
        .clk_40(clk_40), .reset(reset), .fiber_enable(fiber_enable), .rx_valid(rx_valid),
        .crc_match(crc_match), .link_id(link_id), .expected_id(expected_id), .cnt_clear(cnt_clear),
        .link_good(lg_b), .state(st_b), .crc_err_cnt(crc_b), .id_err_cnt(idc_b), .loss_cnt(loss_b));

    cppf_link_status #(.LOCK_COUNT(1), .UNLOCK_COUNT(1), .CNT_W(8)) u_fast (
        .clk_40(clk_40), .reset(reset), .fiber_enable(fiber_enable), .rx_valid(rx_valid),
        .crc_match(crc_match), .link_id(link_id), .expected_id(expected_id), .cnt_clear(cnt_clear),
        .link_good(lg_c), .state(st_c), .crc_err_cnt(crc_c), .id_err_cnt(idc_c), .loss_cnt(loss_c));

    localparam int NI = 3;
    int lock_p[NI] = '{16, 16, 1};
    int unl_p[NI]  = '{4, 4, 1};
    int max_p[NI]  = '{65535, 15, 255};

    // Model state: 0 DISABLED, 1 DOWN, 2 LOCKING, 3 UP; run = length of current good/bad streak.
    int m_st[NI];
    int m_run[NI];
    int m_crc[NI];
    int m_id[NI];
    int m_loss[NI];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit       rst;
        bit       fe;
        bit       v;
        bit       c;
        bit [7:0] id;
        bit       clr;
        int       st;
        int       crc;
        int       idc;
        int       loss;
    } vec_t;

    vec_t tbl[12];

    function automatic int sat_add(int val, int inc, int maxv);
        return (val + inc > maxv) ? maxv : val + inc;
    endfunction

    task automatic check(string name, logic [31:0] act, int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit good, crc_e, id_e, lost;
        good  = rx_valid && crc_match && (link_id == expected_id);
        crc_e = rx_valid && !crc_match;
        id_e  = rx_valid && crc_match && (link_id != expected_id);
        for (int k = 0; k < NI; k++) begin
            lost = 1'b0;
            if (reset) begin
                m_st[k] = fiber_enable ? 1 : 0;
                m_run[k] = 0; m_crc[k] = 0; m_id[k] = 0; m_loss[k] = 0;
            end else if (!fiber_enable) begin
                m_st[k] = 0;
                m_run[k] = 0;
            end else begin
                if (m_st[k] != 0) begin
                    m_crc[k] = sat_add(m_crc[k], int'(crc_e), max_p[k]);
                    m_id[k]  = sat_add(m_id[k], int'(id_e), max_p[k]);
                end
                case (m_st[k])
                    0: m_st[k] = 1;
                    1, 2: begin
                        if (good) begin
                            m_run[k] = m_run[k] + 1;
                            if (m_run[k] >= lock_p[k]) begin
                                m_st[k] = 3; m_run[k] = 0;
                            end else begin
                                m_st[k] = 2;
                            end
                        end else begin
                            m_st[k] = 1; m_run[k] = 0;
                        end
                    end
                    default: begin
                        if (good) begin
                            m_run[k] = 0;
                        end else begin
                            m_run[k] = m_run[k] + 1;
                            if (m_run[k] >= unl_p[k]) begin
                                m_st[k] = 1; m_run[k] = 0; lost = 1'b1;
                            end
                        end
                    end
                endcase
                if (lost) m_loss[k] = sat_add(m_loss[k], 1, 255);
                if (cnt_clear) begin
                    m_crc[k] = 0; m_id[k] = 0; m_loss[k] = 0;
                end
            end
        end
    endtask

    task automatic cmp_inst(string tag, int k, logic lg, logic [2:0] st, logic [31:0] crc,
                            logic [31:0] idc, logic [7:0] loss);
        check($sformatf("%s i%0d state", tag, k), 32'(st), m_st[k]);
        check($sformatf("%s i%0d link_good", tag, k), 32'(lg), (m_st[k] == 3) ? 1 : 0);
        check($sformatf("%s i%0d crc_err_cnt", tag, k), crc, m_crc[k]);
        check($sformatf("%s i%0d id_err_cnt", tag, k), idc, m_id[k]);
        check($sformatf("%s i%0d loss_cnt", tag, k), 32'(loss), m_loss[k]);
    endtask

    task automatic step(string tag);
        @(posedge clk_40);
        model_edge();
        #1;
        cmp_inst(tag, 0, lg_a, st_a, 32'(crc_a), 32'(idc_a), loss_a);
        cmp_inst(tag, 1, lg_b, st_b, 32'(crc_b), 32'(idc_b), loss_b);
        cmp_inst(tag, 2, lg_c, st_c, 32'(crc_c), 32'(idc_c), loss_c);
        $display("[%s] rst=%0b fe=%0b v=%0b crc=%0b id=%02h exp=%02h clr=%0b -> st=%0d lg=%0b crc=%0d id=%0d loss=%0d | sat crc=%0d | fast st=%0d",
                 tag, reset, fiber_enable, rx_valid, crc_match, link_id, expected_id, cnt_clear,
                 st_a, lg_a, crc_a, idc_a, loss_a, crc_b, st_c);
    endtask

    task automatic drive(bit rst, bit fe, bit v, bit c, bit [7:0] id, bit clr);
        reset = rst; fiber_enable = fe; rx_valid = v; crc_match = c; link_id = id; cnt_clear = clr;
    endtask

    initial begin
        int pbad;
        int phase;

        tbl[0]  = '{1, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 8'h05, 0, 1, 1, 0, 0};
        tbl[3]  = '{0, 1, 1, 1, 8'h06, 0, 1, 1, 1, 0};
        tbl[4]  = '{0, 1, 1, 1, 8'h05, 0, 2, 1, 1, 0};
        tbl[5]  = '{0, 1, 1, 1, 8'h05, 0, 2, 1, 1, 0};
        tbl[6]  = '{0, 1, 0, 0, 8'h05, 0, 1, 1, 1, 0};
        tbl[7]  = '{0, 0, 1, 1, 8'h05, 0, 0, 1, 1, 0};
        tbl[8]  = '{0, 0, 1, 0, 8'h05, 0, 0, 1, 1, 0};
        tbl[9]  = '{0, 1, 1, 0, 8'h05, 0, 1, 1, 1, 0};
        tbl[10] = '{0, 1, 1, 0, 8'h05, 1, 1, 0, 0, 0};
        tbl[11] = '{1, 0, 1, 0, 8'h05, 0, 0, 0, 0, 0};

        expected_id = 8'h05;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].fe, tbl[i].v, tbl[i].c, tbl[i].id, tbl[i].clr);
            step($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d state", i), 32'(st_a), tbl[i].st);
            check($sformatf("tbl%0d crc_err_cnt", i), 32'(crc_a), tbl[i].crc);
            check($sformatf("tbl%0d id_err_cnt", i), 32'(idc_a), tbl[i].idc);
            check($sformatf("tbl%0d loss_cnt", i), 32'(loss_a), tbl[i].loss);
        end

        // Lock: LOCKING after the first good BX, UP exactly on the 16th.
        drive(1, 1, 0, 0, 8'h05, 0);
        step("lock_rst");
        check("lock reset state", 32'(st_a), 1);
        for (int i = 1; i <= 16; i++) begin
            drive(0, 1, 1, 1, 8'h05, 0);
            step($sformatf("lock%0d", i));
            if (i == 1) check("lock first good state", 32'(st_a), 2);
            check($sformatf("lock%0d link_good", i), 32'(lg_a), (i == 16) ? 1 : 0);
        end

        // Unlock: three bad then one good keeps UP; four consecutive CRC errors drop it.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 8'h05, 0);
            step("unl_bad3");
        end
        drive(0, 1, 1, 1, 8'h05, 0);
        step("unl_good");
        check("unlock survives 3 bad", 32'(st_a), 3);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0, 8'h05, 0);
            step("unl_bad4");
        end
        check("unlock state", 32'(st_a), 1);
        check("unlock loss_cnt", 32'(loss_a), 1);
        check("unlock crc_err_cnt", 32'(crc_a), 7);

        // ID mismatch while UP.
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 1, 1, 8'h05, 0);
            step("relock");
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 1, 8'h06, 0);
            step("idmis");
        end
        check("idmis id_err_cnt", 32'(idc_a), 2);
        check("idmis crc_err_cnt", 32'(crc_a), 7);
        check("idmis state", 32'(st_a), 3);

        // Saturation on the 4-bit instance, then clear beating a simultaneous error.
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, 0, 8'h05, 0);
            step("sat");
        end
        check("sat crc_err_cnt 4b", 32'(crc_b), 15);
        drive(0, 1, 1, 0, 8'h05, 1);
        step("sat_clr");
        check("clear 4b crc_err_cnt", 32'(crc_b), 0);
        check("clear 16b crc_err_cnt", 32'(crc_a), 0);

        // Mask during LOCKING freezes counters; re-enable returns to DOWN.
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 8'h05, 0);
            step("mask_err");
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1, 8'h05, 0);
            step("mask_lock");
        end
        check("mask pre state", 32'(st_a), 2);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, 8'h05, 0);
            step("mask_off");
            check("mask state", 32'(st_a), 0);
            check("mask link_good", 32'(lg_a), 0);
            check("mask crc frozen", 32'(crc_a), 2);
        end
        drive(0, 1, 1, 1, 8'h05, 0);
        step("mask_on");
        check("reenable state", 32'(st_a), 1);

        // Reset while UP with a bad run of 2.
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 1, 1, 8'h05, 0);
            step("rst_lock");
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 8'h05, 0);
            step("rst_bad");
        end
        check("pre-reset state", 32'(st_a), 3);
        drive(1, 1, 1, 1, 8'h05, 0);
        step("rst_mid");
        check("midrst state", 32'(st_a), 1);
        check("midrst link_good", 32'(lg_a), 0);
        check("midrst crc_err_cnt", 32'(crc_a), 0);
        check("midrst loss_cnt", 32'(loss_a), 0);

        // Random phases of clean, noisy and very noisy links against the model.
        pbad = 1;
        phase = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) begin
                phase = int'($urandom_range(0, 2));
                pbad = (phase == 0) ? 1 : (phase == 1) ? 8 : 30;
            end
            if ($urandom_range(0, 299) == 0) expected_id = 8'($urandom_range(0, 255));
            reset        = ($urandom_range(0, 199) == 0);
            fiber_enable = ($urandom_range(0, 49) != 0);
            cnt_clear    = ($urandom_range(0, 39) == 0);
            rx_valid     = (int'($urandom_range(0, 99)) >= pbad);
            crc_match    = (int'($urandom_range(0, 99)) >= pbad);
            link_id      = (int'($urandom_range(0, 99)) >= pbad) ? expected_id : 8'($urandom_range(0, 255));
            step($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
